// File: rtl/cw_sequencer.sv
// cw_sequencer: issues a loaded program of datapath control words one per clock, with stall and status capture.
module cw_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int KW    = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load_en,
  input  logic [AW-1:0]  load_addr,
  input  logic [KW+23:0] load_word,
  input  logic [AW:0]    prog_len,
  input  logic           start,
  input  logic           stall,
  output logic [4:0]     DA,
  output logic [4:0]     SA,
  output logic [4:0]     SB,
  output logic           W,
  output logic [KW-1:0]  K,
  output logic           BS,
  output logic [4:0]     FS,
  output logic           write,
  output logic           selEN,
  input  logic [3:0]     status,
  output logic [3:0]     status_last,
  output logic           busy,
  output logic           done
);
  localparam int CW = KW + 24;
  localparam logic [CW-1:0] NOP = CW'(1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  logic [1:0]    state;
  logic [AW-1:0] pc;
  logic [AW:0]   len;
  logic [AW:0]   len_c;
  logic          last;
  logic          live;
  logic [CW-1:0] cw;
  logic [CW-1:0] mem [DEPTH];
  assign len_c = prog_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : prog_len;
  assign last = {1'b0, pc} == len - (AW+1)'(1);
  assign busy = state != IDLE;
  assign {DA, SA, SB, W, K, BS, FS, write, selEN} = cw;
  // Program memory survives reset; writes are only accepted while idle.
  always_ff @(posedge clock)
    if (load_en && state == IDLE) mem[load_addr] <= load_word;
  // live marks that cw holds an issued word, so its datapath status is worth capturing.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      len         <= '0;
      cw          <= NOP;
      live        <= 1'b0;
      done        <= 1'b0;
      status_last <= '0;
    end else begin
      done <= 1'b0;
      if (live) status_last <= status;
      case (state)
        IDLE: begin
          cw   <= NOP;
          live <= 1'b0;
          if (start) begin
            len <= len_c;
            pc  <= '0;
            if (len_c == '0) done <= 1'b1;
            else state <= RUN;
          end
        end
        RUN: begin
          cw   <= stall ? NOP : mem[pc];
          live <= !stall;
          if (!stall) begin
            if (last) state <= DRAIN;
            else pc <= pc + AW'(1);
          end
        end
        DRAIN: begin
          cw    <= NOP;
          live  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cw_sequencer.sv
// tb_cw_sequencer: directed scoreboard bench for cw_sequencer.
module tb_cw_sequencer;
  localparam int CW = 88;
  localparam logic [CW-1:0] NOP = 88'd1;
  logic clock = 1'b0, reset = 1'b0, load_en = 1'b0, start = 1'b0, stall = 1'b0;
  logic [3:0] load_addr = '0;
  logic [CW-1:0] load_word = '0;
  logic [4:0] prog_len = '0;
  logic [3:0] status = '0;
  logic [4:0] DA, SA, SB, FS;
  logic W, BS, write, selEN, busy, done;
  logic [63:0] K;
  logic [3:0] status_last;
  logic [CW-1:0] obs;
  logic [CW-1:0] pm [16];
  logic [3:0] exp_sl = '0;
  int checks = 0, errors = 0;
  typedef struct {logic [CW-1:0] cw; logic busy; logic done; logic live;} exp_t;
  exp_t q[$];

  cw_sequencer dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_word(load_word), .prog_len(prog_len), .start(start), .stall(stall),
    .DA(DA), .SA(SA), .SB(SB), .W(W), .K(K), .BS(BS), .FS(FS), .write(write),
    .selEN(selEN), .status(status), .status_last(status_last), .busy(busy), .done(done)
  );
  assign obs = {DA, SA, SB, W, K, BS, FS, write, selEN};

  always #5 clock = ~clock;

  function automatic logic [CW-1:0] mk(int da, int sa, int sb, bit w, longint k, bit bs, int fs, bit wr, bit sel);
    return {5'(da), 5'(sa), 5'(sb), w, 64'(k), bs, 5'(fs), wr, sel};
  endfunction

  task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic load(int a, logic [CW-1:0] w);
    @(negedge clock);
    load_en = 1'b1; load_addr = 4'(a); load_word = w; pm[a] = w;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // Expected per-cycle outputs are queued at start; each negedge pops one and compares.
  task automatic do_run(int n, int sw, int sn, int bl, bit ls, logic [CW-1:0] lw);
    int len = n > 16 ? 16 : n;
    int c = 0;
    exp_t e;
    logic [3:0] st;
    q.delete();
    @(negedge clock);
    if (ls) begin
      load_en = 1'b1; load_addr = 4'd0; load_word = lw; pm[0] = lw;
    end
    q.push_back('{NOP, len > 0, len == 0, 1'b0});
    if (len == 0) q.push_back('{NOP, 1'b0, 1'b0, 1'b0});
    else begin
      for (int i = 0; i < len; i++) begin
        if (i == sw) repeat (sn) q.push_back('{NOP, 1'b1, 1'b0, 1'b0});
        q.push_back('{pm[i], 1'b1, 1'b0, 1'b1});
      end
      q.push_back('{NOP, 1'b0, 1'b1, 1'b0});
      q.push_back('{NOP, 1'b0, 1'b0, 1'b0});
    end
    prog_len = 5'(n); start = 1'b1;
    while (q.size() > 0) begin
      @(negedge clock);
      c++;
      start = 1'b0;
      e = q.pop_front();
      chk($sformatf("cw n=%0d c=%0d", n, c), 128'(obs), 128'(e.cw));
      chk($sformatf("busy n=%0d c=%0d", n, c), 128'(busy), 128'(e.busy));
      chk($sformatf("done n=%0d c=%0d", n, c), 128'(done), 128'(e.done));
      chk($sformatf("status_last n=%0d c=%0d", n, c), 128'(status_last), 128'(exp_sl));
      st = 4'($urandom_range(0, 15));
      status = st;
      if (e.live) exp_sl = st;
      stall = (sn > 0 && c >= sw + 1 && c <= sw + sn);
      load_en = (c == bl);
      if (c == bl) begin
        load_addr = 4'd2; load_word = ~pm[2];
      end
    end
    stall = 1'b0; load_en = 1'b0;
  endtask

  initial begin
    pm[0] = mk(5, 31, 0, 1, 24, 1, 5'b00100, 0, 1);
    pm[1] = mk(7, 31, 0, 1, 39, 1, 5'b00100, 0, 1);
    pm[2] = mk(1, 5, 7, 1, 0, 0, 5'b01000, 0, 1);
    pm[3] = mk(30, 1, 5, 1, 0, 0, 5'b01100, 0, 1);
    pm[4] = mk(17, 30, 0, 1, 2, 1, 5'b10000, 0, 1);
    pm[5] = mk(0, 7, 17, 0, 0, 0, 5'b00000, 1, 1);
    pm[6] = mk(0, 7, 0, 1, 0, 0, 5'b00000, 0, 0);
    pm[7] = mk(0, 0, 0, 1, 4, 1, 5'b01000, 0, 1);
    #12;
    chk("reset cw", 128'(obs), 128'(NOP));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset status_last", 128'(status_last), 128'(0));
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) load(i, pm[i]);
    do_run(8, -1, 0, -1, 1'b0, '0);
    do_run(8, 4, 3, -1, 1'b0, '0);
    do_run(0, -1, 0, -1, 1'b0, '0);
    do_run(8, -1, 0, 3, 1'b0, '0);
    do_run(8, -1, 0, -1, 1'b0, '0);
    status = 4'hF;
    repeat (3) @(negedge clock);
    chk("status_last hold", 128'(status_last), 128'(exp_sl));
    // Abort mid-run: word 3 on the outputs, then asynchronous reset.
    @(negedge clock);
    prog_len = 5'd8; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort pre word3", 128'(obs), 128'(pm[3]));
    #2 reset = 1'b0;
    #1;
    chk("abort cw", 128'(obs), 128'(NOP));
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort status_last", 128'(status_last), 128'(0));
    exp_sl = '0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("abort no done", 128'(done), 128'(0));
      chk("abort idle busy", 128'(busy), 128'(0));
    end
    do_run(8, -1, 0, -1, 1'b0, '0);
    for (int i = 8; i < 16; i++) load(i, mk(i, i + 1, i + 2, 1, 64'h1000 + i, i % 2, i, 0, 1));
    do_run(20, -1, 0, -1, 1'b0, '0);
    do_run(3, -1, 0, -1, 1'b1, mk(9, 9, 9, 1, 64'hDEAD_BEEF, 1, 3, 0, 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
